aes_share_stream_adapter: RTL

- 32-bit stream front-end for the 32-bit masked AES-128 encryption core.
- Input side: collects 32-bit words from a valid/ready stream into d-share plaintext and key buses, then offers them to the core's in_valid/in_ready port.
- Output side: captures the core's d-share ciphertext on out_valid/out_ready and serializes it back into 32-bit words.
- Acts as the producer for the core's input handshake and the consumer for its output handshake.

---
 rtl/aes_share_stream_adapter_pkg.sv | 8 +
 rtl/aes_share_stream_adapter_if.sv | 28 ++
 rtl/aes_share_stream_adapter_serializer.sv | 47 ++++
 rtl/aes_share_stream_adapter.sv | 57 +++++
 4 files changed

// File: rtl/aes_share_stream_adapter_pkg.sv
// aes_share_stream_adapter_pkg: shared widths and FSM encodings for the share stream adapter
package aes_share_stream_adapter_pkg;
  localparam int AES_BLK_W = 128;
  localparam int WORD_W = 32;
  localparam int WORDS_PER_SHARE = 4;
  typedef enum logic {IN_LOAD = 1'b0, IN_PRESENT = 1'b1} in_state_e;
  typedef enum logic {OUT_IDLE = 1'b0, OUT_SEND = 1'b1} out_state_e;
endpackage

// File: rtl/aes_share_stream_adapter_if.sv
// aes_share_stream_adapter_if: word streams and masked-core handshakes around the adapter
interface aes_share_stream_adapter_if #(parameter int D = 2);
  import aes_share_stream_adapter_pkg::*;
  logic [WORD_W-1:0] s_data;
  logic s_valid;
  logic s_ready;
  logic [AES_BLK_W*D-1:0] core_in_shares_plaintext;
  logic [AES_BLK_W*D-1:0] core_in_shares_key;
  logic core_in_valid;
  logic core_in_ready;
  logic [AES_BLK_W*D-1:0] core_out_shares_ciphertext;
  logic core_out_valid;
  logic core_out_ready;
  logic [WORD_W-1:0] m_data;
  logic m_valid;
  logic m_ready;
  logic m_last;
  modport slave (
    input s_data, s_valid, core_in_ready, core_out_shares_ciphertext, core_out_valid, m_ready,
    output s_ready, core_in_shares_plaintext, core_in_shares_key, core_in_valid, core_out_ready,
    output m_data, m_valid, m_last
  );
  modport master (
    output s_data, s_valid, core_in_ready, core_out_shares_ciphertext, core_out_valid, m_ready,
    input s_ready, core_in_shares_plaintext, core_in_shares_key, core_in_valid, core_out_ready,
    input m_data, m_valid, m_last
  );
endinterface

// File: rtl/aes_share_stream_adapter_serializer.sv
// aes_share_word_serializer: captures d-share ciphertext and emits it as 32-bit words
module aes_share_word_serializer
  import aes_share_stream_adapter_pkg::*;
#(parameter int D = 2) (
  input  logic clk,
  input  logic rst,
  input  logic [AES_BLK_W*D-1:0] ct,
  input  logic ct_valid,
  output logic ct_ready,
  output logic [WORD_W-1:0] data,
  output logic valid,
  input  logic ready,
  output logic last
);
  localparam int N_OUT = D * WORDS_PER_SHARE;
  localparam int OW = $clog2(N_OUT);
  localparam logic [OW-1:0] O_LAST = OW'(N_OUT - 1);
  out_state_e state, state_next;
  logic [OW-1:0] o;
  logic [AES_BLK_W*D-1:0] ct_q;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= OUT_IDLE;
    else state <= state_next;
  // capture when idle, return to idle once the final word has left
  always_comb begin
    state_next = state;
    if (state == OUT_IDLE && ct_valid) state_next = OUT_SEND;
    else if (state == OUT_SEND && ready && o == O_LAST) state_next = OUT_IDLE;
  end
  // ciphertext register and output word index
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ct_q <= '0;
      o <= '0;
    end else if (state == OUT_IDLE && ct_valid) begin
      ct_q <= ct;
      o <= '0;
    end else if (state == OUT_SEND && ready) o <= o == O_LAST ? '0 : o + OW'(1);
  // outputs come only from state and registers; data reads zero between blocks
  always_comb begin
    ct_ready = state == OUT_IDLE;
    valid = state == OUT_SEND;
    data = valid ? ct_q[WORD_W*o +: WORD_W] : '0;
    last = valid && o == O_LAST;
  end
endmodule

// File: rtl/aes_share_stream_adapter.sv
// aes_share_stream_adapter: 32-bit stream front-end packing/unpacking d-share AES operands
module aes_share_stream_adapter
  import aes_share_stream_adapter_pkg::*;
#(parameter int D = 2) (
  input logic clk,
  input logic rst,
  aes_share_stream_adapter_if.slave bus
);
  localparam int N_IN = 2 * D * WORDS_PER_SHARE;
  localparam int WW = $clog2(N_IN);
  localparam logic [WW-1:0] W_LAST = WW'(N_IN - 1);
  localparam logic [WW-1:0] W_KEY = WW'(N_IN / 2);
  in_state_e state, state_next;
  logic [WW-1:0] w;
  logic [AES_BLK_W*D-1:0] pt, key;
  logic accept;
  assign accept = bus.s_valid && state == IN_LOAD;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IN_LOAD;
    else state <= state_next;
  // present after the final word, go back to loading once the core takes the operands
  always_comb begin
    state_next = state;
    if (state == IN_LOAD && accept && w == W_LAST) state_next = IN_PRESENT;
    else if (state == IN_PRESENT && bus.core_in_ready) state_next = IN_LOAD;
  end
  // word index and operand registers; share s word k lands at 32*(4s+k), i.e. 32*w linearly
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      w <= '0;
      pt <= '0;
      key <= '0;
    end else if (accept) begin
      w <= w == W_LAST ? '0 : w + WW'(1);
      if (w < W_KEY) pt[WORD_W*w +: WORD_W] <= bus.s_data;
      else key[WORD_W*(w - W_KEY) +: WORD_W] <= bus.s_data;
    end
  // handshake outputs decoded from state
  always_comb begin
    bus.s_ready = state == IN_LOAD;
    bus.core_in_valid = state == IN_PRESENT;
    bus.core_in_shares_plaintext = pt;
    bus.core_in_shares_key = key;
  end
  aes_share_word_serializer #(.D(D)) u_ser (
    .clk(clk),
    .rst(rst),
    .ct(bus.core_out_shares_ciphertext),
    .ct_valid(bus.core_out_valid),
    .ct_ready(bus.core_out_ready),
    .data(bus.m_data),
    .valid(bus.m_valid),
    .ready(bus.m_ready),
    .last(bus.m_last)
  );
endmodule
